// File: rtl/nios_switch_ctrl_pkg.sv
// Shared constants for the switch controller: register word
// addresses and the per-bit debounce state encoding.
package nios_switch_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_EDGE_MODE = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP  = 2'd3;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/nios_switch_debounce.sv
// One switch bit: 2-FF synchroniser, debounce FSM and counter.
// Ports: clk, reset (sync, active-high), pin (raw async input),
//        deb (accepted level), rise/fall (1-cycle pulses, aligned
//        with the cycle in which deb takes its new value).
module nios_switch_debounce
    import nios_switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
            deb   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            unique case (state)
                STABLE: begin
                    if (sync2 != deb) begin
                        state <= COUNTING;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                COUNTING: begin
                    if (sync2 == deb) begin
                        // input went back before the window closed
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        deb   <= sync2;
                        rise  <= sync2;
                        fall  <= ~sync2;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/nios_switch_ctrl.sv
// Avalon-MM switch conditioner: debounced levels, edge capture, irq.
// Ports: clk, reset (sync, active-high), in_port[WIDTH] raw pins,
//        address/chipselect/write_n/writedata slave write side,
//        readdata (registered, 1-cycle latency), irq (level).
module nios_switch_ctrl
    import nios_switch_ctrl_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_mode;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rdata_next;
    logic             wr;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .pin   (in_port[i]),
            .deb   (deb[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign wr           = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // mode bit picks which accepted transition counts as an event
    assign edge_evt = (rise & ~edge_mode) | (fall & edge_mode);
    assign cap_clr  = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;

    always_comb begin
        rdata_next = '0;
        unique case (address)
            ADDR_DATA:      rdata_next = 32'(deb);
            ADDR_EDGE_MODE: rdata_next = 32'(edge_mode);
            ADDR_IRQ_MASK:  rdata_next = 32'(irq_mask);
            ADDR_EDGE_CAP:  rdata_next = 32'(edge_capture);
            default:        rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_mode    <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr && address == ADDR_EDGE_MODE)
                edge_mode <= wdata;
            if (wr && address == ADDR_IRQ_MASK)
                irq_mask <= wdata;
            // a new event wins over a same-cycle clear
            edge_capture <= (edge_capture & ~cap_clr) | edge_evt;
            readdata     <= rdata_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_nios_switch_ctrl.sv
// Directed bench for nios_switch_ctrl with a short debounce window.
// Register vectors from a table, timing corners as hand sequences.
module tb_nios_switch_ctrl;

    localparam int W  = 4;
    localparam int DC = 8;

    logic          clk;
    logic          reset;
    logic [W-1:0]  in_port;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int errors = 0;
    int checks = 0;

    nios_switch_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_port = '0;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    logic [31:0] rv;

    initial begin
        reset      = 1'b1;
        in_port    = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        tbl[0] = '{1'b0, 2'd0, 32'h0,         32'h0};
        tbl[1] = '{1'b0, 2'd1, 32'h0,         32'h0};
        tbl[2] = '{1'b0, 2'd2, 32'h0,         32'h0};
        tbl[3] = '{1'b0, 2'd3, 32'h0,         32'h0};
        tbl[4] = '{1'b1, 2'd1, 32'hFFFF_FFF5, 32'h5};
        tbl[5] = '{1'b1, 2'd2, 32'h0000_000A, 32'hA};
        tbl[6] = '{1'b1, 2'd0, 32'h0000_000F, 32'h0};
        tbl[7] = '{1'b1, 2'd3, 32'h0000_000F, 32'h0};
        tbl[8] = '{1'b1, 2'd1, 32'h0,         32'h0};
        tbl[9] = '{1'b1, 2'd2, 32'hFFFF_0003, 32'h3};

        repeat (2) @(negedge clk);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        // register table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr)
                wr_reg(tbl[i].addr, tbl[i].wdata);
            rd_reg(tbl[i].addr, rv);
            chk($sformatf("tbl%0d", i), rv, tbl[i].exp);
        end
        chk("tbl_irq_idle", 32'(irq), 32'h0);

        // press sw0: latency and irq
        do_reset();
        wr_reg(2'd2, 32'h1);
        @(negedge clk);
        address    = 2'd0;
        in_port[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 10) chk("press_data_early", readdata, 32'h0);
            if (i == 11) begin
                chk("press_data", readdata, 32'h1);
                chk("press_irq_early", 32'(irq), 32'h0);
            end
            if (i == 12) chk("press_irq", 32'(irq), 32'h1);
        end
        rd_reg(2'd3, rv);
        chk("press_cap", rv, 32'h1);
        wr_reg(2'd3, 32'h1);
        chk("w1c_irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        chk("w1c_irq", 32'(irq), 32'h0);

        // mask off with pending capture
        in_port[0] = 1'b0;
        repeat (14) @(negedge clk);
        in_port[0] = 1'b1;
        repeat (14) @(negedge clk);
        chk("repress_irq", 32'(irq), 32'h1);
        wr_reg(2'd2, 32'h0);
        @(negedge clk);
        chk("mask_irq", 32'(irq), 32'h0);
        repeat (3) @(negedge clk);
        chk("mask_irq_hold", 32'(irq), 32'h0);
        rd_reg(2'd3, rv);
        chk("mask_cap_kept", rv, 32'h1);

        // bounce on sw1
        do_reset();
        @(negedge clk);
        address = 2'd0;
        for (int i = 0; i < 30; i++) begin
            in_port[1] = ((i / 3) % 2 == 0);
            @(negedge clk);
            if (readdata != 32'h0)
                chk($sformatf("bounce_data%0d", i), readdata, 32'h0);
            else
                chk("bounce_data", readdata, 32'h0);
        end
        in_port[1] = 1'b1;
        repeat (12) @(negedge clk);
        chk("bounce_settle", readdata, 32'h2);
        rd_reg(2'd3, rv);
        chk("bounce_cap", rv, 32'h2);
        wr_reg(2'd3, 32'h2);
        repeat (5) @(negedge clk);
        rd_reg(2'd3, rv);
        chk("bounce_once", rv, 32'h0);

        // falling-edge mode on sw2
        do_reset();
        wr_reg(2'd1, 32'h4);
        in_port[2] = 1'b1;
        repeat (14) @(negedge clk);
        rd_reg(2'd3, rv);
        chk("fall_no_press", rv, 32'h0);
        rd_reg(2'd0, rv);
        chk("fall_data", rv, 32'h4);
        in_port[2] = 1'b0;
        repeat (14) @(negedge clk);
        rd_reg(2'd3, rv);
        chk("fall_release", rv, 32'h4);

        // clear collides with a new rising edge
        do_reset();
        in_port[0] = 1'b1;
        repeat (14) @(negedge clk);
        in_port[0] = 1'b0;
        repeat (14) @(negedge clk);
        rd_reg(2'd3, rv);
        chk("coll_pre", rv, 32'h1);
        @(negedge clk);
        in_port[0] = 1'b1;
        repeat (10) @(negedge clk);
        address    = 2'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_reg(2'd3, rv);
        chk("coll_set_wins", rv, 32'h1);
        wr_reg(2'd3, 32'h1);
        rd_reg(2'd3, rv);
        chk("coll_cleared", rv, 32'h0);

        // reset during counting
        do_reset();
        wr_reg(2'd2, 32'hF);
        wr_reg(2'd1, 32'hA);
        in_port[0] = 1'b1;
        repeat (14) @(negedge clk);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        in_port[3] = 1'b1;
        repeat (5) @(negedge clk);
        address = 2'd0;
        in_port[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 10) chk("rst_data_early", readdata, 32'h0);
            if (i == 11) chk("rst_data", readdata, 32'h8);
        end
        rd_reg(2'd1, rv);
        chk("rst_mode", rv, 32'h0);
        rd_reg(2'd2, rv);
        chk("rst_mask", rv, 32'h0);
        rd_reg(2'd3, rv);
        chk("rst_cap", rv, 32'h8);
        chk("rst_irq_after", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
